clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider.sv | 103 ++++++++++
 tb/tb_clock_divider.sv | 114 +++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Integer clock divider: 50% duty clk_out at clk/DIVISOR plus a one-cycle tick
// marking the last clk cycle of each output period. Odd divisors use a negedge stage.
module clock_divider #(
  parameter int unsigned DIVISOR = 2
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out,
  output logic tick
);

  localparam int unsigned CNT_W = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_c;

  assign wrap_c = (cnt_q == CNT_MAX);

  // Modulo-DIVISOR counter; explicit wrap keeps non-power-of-two divisors in range.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (wrap_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter is held at zero in reset and CNT_MAX is never zero, so tick is low in reset.
  assign tick = wrap_c;

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("clock_divider: DIVISOR must be >= 2");
      assign clk_out = 1'b0;
    end else if ((DIVISOR % 2) == 0) begin : g_even
      localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIVISOR / 2 - 1);

      logic q_p_q;
      logic q_p_d;

      always_comb begin
        q_p_d = q_p_q;
        if ((cnt_q == HALF_CNT) || wrap_c) begin
          q_p_d = ~q_p_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_p_q <= 1'b0;
        end else begin
          q_p_q <= q_p_d;
        end
      end

      assign clk_out = q_p_q;
    end else begin : g_odd
      localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'((DIVISOR - 1) / 2 - 1);

      logic q_p_q;
      logic q_p_d;
      logic q_n_q;

      // q_p is high for (DIVISOR+1)/2 cycles; ANDing with its half-cycle-late copy trims half a cycle.
      always_comb begin
        q_p_d = q_p_q;
        if (wrap_c) begin
          q_p_d = 1'b0;
        end else if (cnt_q == RISE_CNT) begin
          q_p_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_p_q <= 1'b0;
        end else begin
          q_p_q <= q_p_d;
        end
      end

      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          q_n_q <= 1'b0;
        end else begin
          q_n_q <= q_p_q;
        end
      end

      assign clk_out = q_p_q & q_n_q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider over several even and odd divisors with
// random reset pulses, checked against a half-cycle phase model.
module tb_clock_divider;

  localparam int N = 6;
  localparam int DIVS [N] = '{2, 3, 5, 10, 16, 1234};

  logic         clk;
  logic         rst;
  logic [N-1:0] co;
  logic [N-1:0] tk;

  int total;
  int bad;
  int t;
  bit in_rst;

  clock_divider #(.DIVISOR(2))    u_d2    (.clk(clk), .rst(rst), .clk_out(co[0]), .tick(tk[0]));
  clock_divider #(.DIVISOR(3))    u_d3    (.clk(clk), .rst(rst), .clk_out(co[1]), .tick(tk[1]));
  clock_divider #(.DIVISOR(5))    u_d5    (.clk(clk), .rst(rst), .clk_out(co[2]), .tick(tk[2]));
  clock_divider #(.DIVISOR(10))   u_d10   (.clk(clk), .rst(rst), .clk_out(co[3]), .tick(tk[3]));
  clock_divider #(.DIVISOR(16))   u_d16   (.clk(clk), .rst(rst), .clk_out(co[4]), .tick(tk[4]));
  clock_divider #(.DIVISOR(1234)) u_d1234 (.clk(clk), .rst(rst), .clk_out(co[5]), .tick(tk[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t counts clk edges since reset release, starting from a point just after a falling edge.
  // u = t+1 is then 2k after rising edge k; clk_out is high in the upper half of each 2*D window.
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int   d;
      int   u;
      logic ec;
      logic et;
      d  = DIVS[i];
      u  = t + 1;
      ec = in_rst ? 1'b0 : ((u % (2 * d)) >= d);
      et = in_rst ? 1'b0 : (((u / 2) % d) == (d - 1));
      total++;
      assert (co[i] === ec) else begin
        bad++;
        $error("FAIL clk_out D=%0d t=%0d rst=%0b observed=%0b expected=%0b", d, t, in_rst, co[i], ec);
      end
      total++;
      assert (tk[i] === et) else begin
        bad++;
        $error("FAIL tick D=%0d t=%0d rst=%0b observed=%0b expected=%0b", d, t, in_rst, tk[i], et);
      end
    end
  endtask

  task automatic run_halves(input int n);
    repeat (n) begin
      @(clk);
      #1;
      t++;
      check_all();
    end
  endtask

  task automatic release_rst();
    #2;
    rst    = 1'b0;
    in_rst = 1'b0;
    t      = 0;
    #1;
    check_all();
  endtask

  task automatic pulse_rst(input int cycles);
    #2;
    rst    = 1'b1;
    in_rst = 1'b1;
    #1;
    check_all();
    run_halves(2 * cycles);
    release_rst();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    t      = 0;
    in_rst = 1'b1;
    rst    = 1'b1;

    #1;
    check_all();
    run_halves(20);
    release_rst();

    // D=10: after rising edge 7 the output is in its high phase; reset must drop it at once.
    run_halves(14);
    total++;
    assert (co[3] === 1'b1) else begin
      bad++;
      $error("FAIL d10_high_before_reset observed=%0b expected=1", co[3]);
    end
    pulse_rst(3);
    run_halves(24);

    for (int r = 0; r < 20; r++) begin
      run_halves(2 * $urandom_range(2, 250));
      pulse_rst($urandom_range(1, 8));
    end

    run_halves(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
